// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants, select encodings and helpers for the dsp_mac_pipe slice
//   OP_*      : bit positions of the per-beat OPMODE fields
//   zsel_e    : post-adder Z operand select
//   xsel_e    : post-adder X operand select
//   ctl_t     : decoded post-adder controls carried down the pipeline
//   sat_limit : signed max/min of a given width, for saturation
package dsp_pkg;

    localparam int OP_POSTSUB = 7;
    localparam int OP_PRESUB  = 6;
    localparam int OP_CSEL    = 5;
    localparam int OP_PREEN   = 4;
    localparam int OP_ZHI     = 3;
    localparam int OP_ZLO     = 2;
    localparam int OP_XHI     = 1;
    localparam int OP_XLO     = 0;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_CAT  = 2'd3
    } xsel_e;

    typedef struct packed {
        logic  sub;
        logic  cin;
        zsel_e zsel;
        xsel_e xsel;
    } ctl_t;

    localparam int                 LIM_W   = 128;
    localparam logic [LIM_W-1:0]   LIM_ONE = {{(LIM_W-1){1'b0}}, 1'b1};

    // Returns the most negative (neg=1) or most positive (neg=0) signed value
    // of width w, zero-extended to LIM_W bits; callers cast down to w.
    function automatic logic [LIM_W-1:0] sat_limit(input int w, input logic neg);
        logic [LIM_W-1:0] msb;
        msb = LIM_ONE << (w - 1);
        return neg ? msb : msb - LIM_ONE;
    endfunction

endpackage

// File: rtl/dsp_post_adder.sv
// dsp_post_adder: combinational Z/X select, add/sub, saturation, overflow and pattern detect
//   ctl        : decoded sub / carry-in / Z select / X select of the beat in stage 2
//   m          : stage-2 product (sign-extended when selected as X)
//   c, pcin    : stage-2 piped C and cascade input
//   p          : current P register (accumulator feedback)
//   cat        : low P_WIDTH bits of {D,A,B}
//   p_next     : post-saturation result
//   carry_next : carry out of the unsigned add, or borrow of the subtract
//   ovf_next   : signed overflow of the P_WIDTH+1-bit sum
//   pat_next   : masked pattern match on p_next
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter int                 P_WIDTH = 48,
    parameter int                 M_WIDTH = 36,
    parameter int                 SAT     = 0,
    parameter logic [P_WIDTH-1:0] PATTERN = '0,
    parameter logic [P_WIDTH-1:0] MASK    = '0
) (
    input  ctl_t               ctl,
    input  logic [M_WIDTH-1:0] m,
    input  logic [P_WIDTH-1:0] c,
    input  logic [P_WIDTH-1:0] pcin,
    input  logic [P_WIDTH-1:0] p,
    input  logic [P_WIDTH-1:0] cat,
    output logic [P_WIDTH-1:0] p_next,
    output logic               carry_next,
    output logic               ovf_next,
    output logic               pat_next
);

    logic [P_WIDTH-1:0] z, x, m_ext;
    logic [P_WIDTH:0]   cx, usum;
    logic               sgn;

    always_comb begin
        m_ext = P_WIDTH'($signed(m));
        z = ctl.zsel == Z_PCIN ? pcin :
            ctl.zsel == Z_P    ? p    :
            ctl.zsel == Z_C    ? c    : '0;
        x = ctl.xsel == X_M    ? m_ext :
            ctl.xsel == X_P    ? p     :
            ctl.xsel == X_CAT  ? cat   : '0;
        cx = {{P_WIDTH{1'b0}}, ctl.cin};
        usum = ctl.sub ? {1'b0, z} - {1'b0, x} - cx : {1'b0, z} + {1'b0, x} + cx;
        // Bit P_WIDTH of the sign-extended sum differs from the unsigned one only
        // by the two operand sign bits, for both add and subtract.
        sgn = z[P_WIDTH-1] ^ x[P_WIDTH-1] ^ usum[P_WIDTH];
        carry_next = usum[P_WIDTH];
        ovf_next = sgn ^ usum[P_WIDTH-1];
        p_next = (SAT != 0 && ovf_next) ? P_WIDTH'(sat_limit(P_WIDTH, sgn)) : usum[P_WIDTH-1:0];
        pat_next = ((p_next ^ PATTERN) & ~MASK) == '0;
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage valid-tagged pre-adder / multiplier / post-adder DSP slice
//   CLK, RSTN      : rising-edge clock, asynchronous active-low reset
//   CE, SCLR       : global clock enable, synchronous clear (wins over CE)
//   IN_VALID       : input beat valid
//   A, B, D, C     : multiplier, pre-adder and post-adder operands
//   PCIN, CARRYIN  : cascade input and post-adder carry
//   OPMODE         : per-beat mode
//   OUT_VALID      : result valid
//   BCOUT, M       : stage-1 pre-adder and stage-2 product registers
//   P, PCOUT       : stage-3 result (PCOUT mirrors P for cascading)
//   CARRYOUT       : registered carry/borrow
//   OVERFLOW       : registered signed overflow of P
//   PATDET         : registered masked pattern match of P
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int                 A_WIDTH = 18,
    parameter int                 B_WIDTH = 18,
    parameter int                 P_WIDTH = 48,
    parameter int                 SAT     = 0,
    parameter logic [P_WIDTH-1:0] PATTERN = '0,
    parameter logic [P_WIDTH-1:0] MASK    = '0
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       CE,
    input  logic                       SCLR,
    input  logic                       IN_VALID,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         D,
    input  logic [P_WIDTH-1:0]         C,
    input  logic [P_WIDTH-1:0]         PCIN,
    input  logic                       CARRYIN,
    input  logic [7:0]                 OPMODE,
    output logic                       OUT_VALID,
    output logic [B_WIDTH-1:0]         BCOUT,
    output logic [A_WIDTH+B_WIDTH-1:0] M,
    output logic [P_WIDTH-1:0]         P,
    output logic [P_WIDTH-1:0]         PCOUT,
    output logic                       CARRYOUT,
    output logic                       OVERFLOW,
    output logic                       PATDET
);

    localparam int M_WIDTH = A_WIDTH + B_WIDTH;

    typedef struct packed {
        logic               v;
        logic [7:0]         op;
        logic               cin;
        logic [A_WIDTH-1:0] a;
        logic [B_WIDTH-1:0] b;
        logic [B_WIDTH-1:0] d;
        logic [P_WIDTH-1:0] c;
        logic [P_WIDTH-1:0] pcin;
    } in_t;

    // After stage 0 only the decoded post-adder controls travel on; A, B and D
    // stay along for the multiplier and the {D,A,B} X operand.
    typedef struct packed {
        logic               v;
        ctl_t               ctl;
        logic [A_WIDTH-1:0] a;
        logic [B_WIDTH-1:0] b;
        logic [B_WIDTH-1:0] d;
        logic [P_WIDTH-1:0] c;
        logic [P_WIDTH-1:0] pcin;
    } pipe_t;

    in_t                s0_q, s0_d;
    pipe_t              s1_q, s1_d, s2_q, s2_d;
    logic [B_WIDTH-1:0] bc_q, bc_d, pre;
    logic [M_WIDTH-1:0] m_q, m_d;
    logic [P_WIDTH-1:0] p_q, p_d, p_next;
    logic               co_q, co_d, co_next;
    logic               ovf_q, ovf_d, ovf_next;
    logic               pat_q, pat_d, pat_next;
    logic               ov_q, ov_d;

    dsp_post_adder #(
        .P_WIDTH (P_WIDTH),
        .M_WIDTH (M_WIDTH),
        .SAT     (SAT),
        .PATTERN (PATTERN),
        .MASK    (MASK)
    ) u_post (
        .ctl        (s2_q.ctl),
        .m          (m_q),
        .c          (s2_q.c),
        .pcin       (s2_q.pcin),
        .p          (p_q),
        .cat        (P_WIDTH'({s2_q.d, s2_q.a, s2_q.b})),
        .p_next     (p_next),
        .carry_next (co_next),
        .ovf_next   (ovf_next),
        .pat_next   (pat_next)
    );

    always_comb begin
        pre = s0_q.op[OP_PREEN] ? (s0_q.op[OP_PRESUB] ? s0_q.d - s0_q.b : s0_q.d + s0_q.b) : s0_q.b;
        s0_d = s0_q;
        s1_d = s1_q;
        s2_d = s2_q;
        bc_d = bc_q;
        m_d = m_q;
        p_d = p_q;
        co_d = co_q;
        ovf_d = ovf_q;
        pat_d = pat_q;
        ov_d = ov_q;
        if (SCLR) begin
            s0_d = '0;
            s1_d = '0;
            s2_d = '0;
            bc_d = '0;
            m_d = '0;
            p_d = '0;
            co_d = 1'b0;
            ovf_d = 1'b0;
            pat_d = 1'b0;
            ov_d = 1'b0;
        end else if (CE) begin
            s0_d = '{v: IN_VALID, op: OPMODE, cin: CARRYIN, a: A, b: B, d: D, c: C, pcin: PCIN};
            s1_d.v = s0_q.v;
            s1_d.ctl.sub = s0_q.op[OP_POSTSUB];
            s1_d.ctl.cin = s0_q.op[OP_CSEL] & s0_q.cin;
            s1_d.ctl.zsel = zsel_e'(s0_q.op[OP_ZHI:OP_ZLO]);
            s1_d.ctl.xsel = xsel_e'(s0_q.op[OP_XHI:OP_XLO]);
            s1_d.a = s0_q.a;
            s1_d.b = s0_q.b;
            s1_d.d = s0_q.d;
            s1_d.c = s0_q.c;
            s1_d.pcin = s0_q.pcin;
            bc_d = pre;
            s2_d = s1_q;
            // Both operands sign-extended to the product width; the low bits of
            // the unsigned product are then the signed product.
            m_d = {{A_WIDTH{bc_q[B_WIDTH-1]}}, bc_q} * {{B_WIDTH{s1_q.a[A_WIDTH-1]}}, s1_q.a};
            ov_d = s2_q.v;
            // Result registers only move on a valid beat so bubbles cannot
            // disturb an accumulation through Z=P or X=P.
            if (s2_q.v) begin
                p_d = p_next;
                co_d = co_next;
                ovf_d = ovf_next;
                pat_d = pat_next;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
            bc_q <= '0;
            m_q <= '0;
            p_q <= '0;
            co_q <= 1'b0;
            ovf_q <= 1'b0;
            pat_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            bc_q <= bc_d;
            m_q <= m_d;
            p_q <= p_d;
            co_q <= co_d;
            ovf_q <= ovf_d;
            pat_q <= pat_d;
            ov_q <= ov_d;
        end
    end

    assign OUT_VALID = ov_q;
    assign BCOUT = bc_q;
    assign M = m_q;
    assign P = p_q;
    assign PCOUT = p_q;
    assign CARRYOUT = co_q;
    assign OVERFLOW = ovf_q;
    assign PATDET = pat_q;

endmodule
